// File: rtl/coincidence_scan_sequencer.sv
// coincidence_scan_sequencer: arbitrates the recorder CSR and scans the reference histogram for its rising edge.
// Optional watchdog on the wait states: define COINCIDENCE_SCAN_TIMEOUT_EN.
module coincidence_scan_sequencer #(
    parameter int CHANNEL_COUNT = 2,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 64,
    parameter int SUM_WIDTH = 8,
    parameter int REF_CHANNEL = 0,
    parameter int SETTLE_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int MUXSEL_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int ADDR_W = $clog2(SAMPLE_CLKS_PER_COINCIDENCE)
) (
    input  logic                 sysClk,
    input  logic                 sysReset_n,
    input  logic                 scanStart,
    input  logic [SUM_WIDTH-1:0] threshold,
    input  logic [ADDR_W-1:0]    coincidenceOffset,
    input  logic                 realignEnable,
    input  logic                 hostCsrStrobe,
    input  logic [31:0]          hostGPIO_OUT,
    input  logic [31:0]          recCsr,
    output logic                 recCsrStrobe,
    output logic [31:0]          recGPIO_OUT,
    output logic                 scanBusy,
    output logic                 scanDone,
    output logic                 scanError,
    output logic [ADDR_W-1:0]    edgeAddress,
    output logic [ADDR_W-1:0]    coincidenceAddress,
    output logic                 hostDropped
);
    localparam int N = SAMPLE_CLKS_PER_COINCIDENCE;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0] N_EXT = (ADDR_W + 1)'(N);

    typedef enum logic [3:0] {
        IDLE, ARM, WAIT_HI, WAIT_LO, RD_ISSUE, RD_MATCH, RD_SETTLE, RD_EVAL, WR_COINC, REALIGN, DONE
    } state_t;

    state_t state, state_d;
    logic busy_meta, busy_sync, first, realign_en, strobe_d, hit, last, match, timeout, unused_bits;
    logic [31:0] gpio_d, cnt;
    logic [SUM_WIDTH-1:0] prev, rb_count;
    logic [ADDR_W-1:0] addr, hit_addr, coinc, rb_addr;
    logic [ADDR_W:0] coinc_sum, coinc_wrap;
    logic [MUXSEL_W-1:0] rb_mux;

    assign rb_count = recCsr[0 +: SUM_WIDTH];
    assign rb_addr = recCsr[SUM_WIDTH +: ADDR_W];
    assign rb_mux = recCsr[24 +: MUXSEL_W];
    assign match = rb_addr == addr && rb_mux == MUXSEL_W'(REF_CHANNEL);
    assign last = addr == LAST;
    // the first read (address N-1) only seeds prev and can never be an edge
    assign hit = !first && rb_count >= threshold && prev < threshold;
    assign coinc_sum = {1'b0, hit_addr} + {1'b0, coincidenceOffset};
    assign coinc_wrap = (coinc_sum >= N_EXT) ? coinc_sum - N_EXT : coinc_sum;
    assign coinc = coinc_wrap[ADDR_W-1:0];
    assign scanBusy = state != IDLE && state != DONE;
    assign scanDone = state == DONE;
    assign unused_bits = ^{recCsr, 32'(TIMEOUT_CYCLES)};

`ifdef COINCIDENCE_SCAN_TIMEOUT_EN
    assign timeout = (state == WAIT_HI || state == WAIT_LO || state == RD_MATCH) && cnt >= 32'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        strobe_d = 1'b0;
        gpio_d = '0;
        case (state)
            IDLE, DONE: begin
                state_d = (state == IDLE && scanStart) ? ARM : IDLE;
                strobe_d = hostCsrStrobe && !(state == IDLE && scanStart);
                gpio_d = hostGPIO_OUT;
            end
            ARM: begin
                strobe_d = 1'b1;
                gpio_d = 32'h8000_0000;
                state_d = WAIT_HI;
            end
            WAIT_HI: state_d = busy_sync ? WAIT_LO : WAIT_HI;
            WAIT_LO: state_d = busy_sync ? WAIT_LO : RD_ISSUE;
            RD_ISSUE: begin
                strobe_d = 1'b1;
                gpio_d[24 +: MUXSEL_W] = MUXSEL_W'(REF_CHANNEL);
                gpio_d[0 +: ADDR_W] = addr;
                state_d = RD_MATCH;
            end
            RD_MATCH: state_d = match ? RD_SETTLE : RD_MATCH;
            RD_SETTLE: state_d = (cnt >= 32'(SETTLE_CYCLES - 1)) ? RD_EVAL : RD_SETTLE;
            RD_EVAL: state_d = hit ? WR_COINC : (!first && last) ? DONE : RD_ISSUE;
            WR_COINC: begin
                strobe_d = 1'b1;
                gpio_d = 32'h4000_0000 | 32'(coinc);
                state_d = realign_en ? REALIGN : DONE;
            end
            // one quiet cycle keeps the realign strobe apart from the coincidence write
            REALIGN: begin
                strobe_d = cnt != 0;
                gpio_d = 32'h2000_0000;
                state_d = (cnt != 0) ? DONE : REALIGN;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = DONE;
    end

    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            state <= IDLE;
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
            cnt <= '0;
            recCsrStrobe <= 1'b0;
            recGPIO_OUT <= '0;
            scanError <= 1'b0;
            hostDropped <= 1'b0;
            edgeAddress <= '0;
            coincidenceAddress <= '0;
            realign_en <= 1'b0;
            first <= 1'b0;
            addr <= '0;
            prev <= '0;
            hit_addr <= '0;
        end else begin
            state <= state_d;
            busy_meta <= recCsr[31];
            busy_sync <= busy_meta;
            cnt <= (state_d != state) ? '0 : cnt + 32'd1;
            recCsrStrobe <= strobe_d;
            if (strobe_d) recGPIO_OUT <= gpio_d;
            if (state == IDLE && scanStart) begin
                realign_en <= realignEnable;
                scanError <= 1'b0;
                hostDropped <= 1'b0;
                addr <= LAST;
                first <= 1'b1;
            end
            if (hostCsrStrobe && (scanBusy || (state == IDLE && scanStart))) hostDropped <= 1'b1;
            if (state == RD_EVAL) begin
                first <= 1'b0;
                prev <= rb_count;
                addr <= last ? '0 : addr + 1'b1;
                if (hit) hit_addr <= addr;
                if (!first && !hit && last) scanError <= 1'b1;
            end
            if (timeout) scanError <= 1'b1;
            if (state == WR_COINC) begin
                edgeAddress <= hit_addr;
                coincidenceAddress <= coinc;
            end
        end
    end
endmodule

// File: tb/tb_coincidence_scan_sequencer.sv
// tb_coincidence_scan_sequencer: recorder model plus scan reference model driving randomized and directed scans.
module tb_coincidence_scan_sequencer;
    localparam int N = 64;

    logic clk = 1'b0, rst_n = 1'b0, scan_start = 1'b0, realign_enable = 1'b0, host_strobe = 1'b0;
    logic [7:0] threshold = '0;
    logic [5:0] coincidence_offset = '0;
    logic [31:0] host_gpio = '0, rec_csr = '0, rec_gpio;
    logic rec_strobe, scan_busy, scan_done, scan_error, host_dropped;
    logic [5:0] edge_address, coincidence_address;

    logic [7:0] hist [N];
    logic [31:0] writes [$];
    logic [31:0] rd_cmd;
    bit rd_pend;
    int busy_pre, busy_len, rd_wait, cyc, last_cyc = -10, b2b;
    int checks = 0, errors = 0, exp_edge = 0, exp_coinc = 0;

    coincidence_scan_sequencer dut (
        .sysClk(clk), .sysReset_n(rst_n), .scanStart(scan_start), .threshold(threshold),
        .coincidenceOffset(coincidence_offset), .realignEnable(realign_enable),
        .hostCsrStrobe(host_strobe), .hostGPIO_OUT(host_gpio), .recCsr(rec_csr),
        .recCsrStrobe(rec_strobe), .recGPIO_OUT(rec_gpio), .scanBusy(scan_busy), .scanDone(scan_done),
        .scanError(scan_error), .edgeAddress(edge_address), .coincidenceAddress(coincidence_address),
        .hostDropped(host_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // recorder: logs every CSR write, runs a busy pulse on start, answers reads after a random delay
    initial forever begin
        @(negedge clk);
        cyc++;
        if (busy_pre > 0) begin
            busy_pre--;
            if (busy_pre == 0) rec_csr[31] = 1'b1;
        end else if (busy_len > 0) begin
            busy_len--;
            if (busy_len == 0) rec_csr[31] = 1'b0;
        end
        if (rd_pend) begin
            if (rd_wait == 0) begin
                rec_csr[30:0] = '0;
                rec_csr[24] = rd_cmd[24];
                rec_csr[13:8] = rd_cmd[5:0];
                rec_csr[7:0] = hist[rd_cmd[5:0]];
                rd_pend = 1'b0;
            end else rd_wait--;
        end
        if (rec_strobe) begin
            if (cyc - last_cyc == 1) b2b++;
            last_cyc = cyc;
            writes.push_back(rec_gpio);
            if (rec_gpio == 32'h8000_0000) begin
                busy_pre = 2;
                busy_len = $urandom_range(3, 10);
                rec_csr[30:0] = '0;
            end else if (rec_gpio[31:29] == 3'b000) begin
                rd_cmd = rec_gpio;
                rd_wait = $urandom_range(0, 5);
                rd_pend = 1'b1;
            end
        end
    end

    task automatic fill(input int lo, input int len, input logic [7:0] val);
        for (int i = 0; i < len; i++) hist[(lo + i) % N] = val;
    endtask

    task automatic run_scan(input int th, input int off, input bit realign, input int host_mode);
        int edge_a;
        bit done;
        logic [31:0] exp_q [$];
        edge_a = -1;
        for (int a = 0; a < N; a++)
            if (edge_a < 0 && int'(hist[a]) >= th && int'(hist[(a + N - 1) % N]) < th) edge_a = a;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'(N - 1));
        for (int a = 0; a <= ((edge_a < 0) ? N - 1 : edge_a); a++) exp_q.push_back(32'(a));
        if (edge_a >= 0) begin
            exp_edge = edge_a;
            exp_coinc = (edge_a + off) % N;
            exp_q.push_back(32'h4000_0000 | 32'(exp_coinc));
            if (realign) exp_q.push_back(32'h2000_0000);
        end
        writes.delete();
        b2b = 0;
        threshold = 8'(th);
        coincidence_offset = 6'(off);
        realign_enable = realign;
        @(posedge clk); #1;
        scan_start = 1'b1;
        if (host_mode == 1) begin
            host_strobe = 1'b1;
            host_gpio = 32'h0100_0009;
        end
        @(posedge clk); #1;
        scan_start = 1'b0;
        host_strobe = 1'b0;
        realign_enable = !realign;
        check("busy_on", 32'(scan_busy), 1);
        check("drop_at_start", 32'(host_dropped), 32'(host_mode == 1));
        check("err_clr", 32'(scan_error), 0);
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (host_mode == 2 && i == 10) begin
                host_strobe = 1'b1;
                host_gpio = 32'h0100_0009;
            end
            @(posedge clk); #1;
            host_strobe = 1'b0;
            if (scan_done) begin
                done = 1'b1;
                check("busy_at_done", 32'(scan_busy), 0);
            end
        end
        check("done_seen", 32'(done), 1);
        @(posedge clk); #1;
        check("done_pulse", 32'(scan_done), 0);
        check("n_writes", 32'(writes.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < writes.size(); i++)
            check($sformatf("write%0d", i), writes[i], exp_q[i]);
        check("error", 32'(scan_error), 32'(edge_a < 0));
        check("edge", 32'(edge_address), 32'(exp_edge));
        check("coinc", 32'(coincidence_address), 32'(exp_coinc));
        check("dropped", 32'(host_dropped), 32'(host_mode != 0));
        check("spacing", 32'(b2b), 0);
    endtask

    initial begin
        int n;
        bit seen;
        fill(0, N, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", 32'(rec_strobe), 0);
        check("rst_gpio", rec_gpio, 0);
        check("rst_busy", 32'(scan_busy), 0);
        check("rst_done", 32'(scan_done), 0);
        check("rst_err", 32'(scan_error), 0);
        check("rst_drop", 32'(host_dropped), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        host_strobe = 1'b1;
        host_gpio = 32'h0100_0005;
        writes.delete();
        @(posedge clk); #1;
        host_strobe = 1'b0;
        check("host_strobe", 32'(rec_strobe), 1);
        check("host_gpio", rec_gpio, 32'h0100_0005);
        repeat (5) @(posedge clk);
        #1;
        check("host_count", 32'(writes.size()), 1);

        fill(20, 32, 8'd8);
        run_scan(4, 3, 1'b0, 0);
        fill(0, N, 8'd0);
        fill(60, 10, 8'd9);
        run_scan(5, 10, 1'b1, 2);
        fill(0, N, 8'd0);
        run_scan(1, 7, 1'b1, 0);
        for (int a = 0; a < N; a++) hist[a] = 8'($urandom_range(0, 20));
        run_scan(0, 5, 1'b0, 1);
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < N; a++) hist[a] = 8'($urandom_range(0, 15));
            run_scan($urandom_range(0, 15), $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        for (int a = 0; a < N; a++) hist[a] = 8'($urandom_range(0, 15));
        writes.delete();
        threshold = 8'd200;
        @(posedge clk); #1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            seen = writes.size() >= 2 && !rd_pend;
        end
        check("settle_reached", 32'(seen), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_edge = 0;
        exp_coinc = 0;
        check("mid_rst_strobe", 32'(rec_strobe), 0);
        check("mid_rst_gpio", rec_gpio, 0);
        check("mid_rst_busy", 32'(scan_busy), 0);
        check("mid_rst_done", 32'(scan_done), 0);
        check("mid_rst_err", 32'(scan_error), 0);
        check("mid_rst_edge", 32'(edge_address), 0);
        check("mid_rst_coinc", 32'(coincidence_address), 0);
        rst_n = 1'b1;
        n = writes.size();
        repeat (60) @(posedge clk);
        #1;
        check("post_rst_writes", 32'(writes.size()), 32'(n));
        fill(0, N, 8'd0);
        fill(33, 5, 8'd12);
        run_scan(12, 40, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
